// File: rtl/looper_engine.sv
// rtl/looper_engine.sv - multi-track step looper with record, overdub, mute and clear sweep
//
// Step sequencer memory of TRACKS x STEPS note words. On each tempo tick
// in PLAY, armed tracks record data_in at the current step and the step
// pointer advances around a programmable loop. A clear request sweeps
// every address once and zeroes the masked tracks.
//
// Ports:
//   clk         system clock, rising edge
//   reset       synchronous active-low reset
//   run         level, playback/record enable
//   step_tick   one-cycle tempo pulse, advances step pointer
//   rewind      one-cycle pulse, step pointer to 0
//   rec_en      per-track record arm
//   overdub     0 = overwrite, 1 = OR into stored word
//   data_in     note word to record
//   loop_len    loop length in steps, 0 = STEPS
//   mute        per-track output mute
//   clear_req   one-cycle pulse, start clear sweep
//   clear_mask  tracks to erase, sampled with clear_req
//   notes_out   registered note words, track i at [(i+1)*NOTE_W-1 : i*NOTE_W]
//   step_pos    current step pointer
//   loop_wrap   one-cycle pulse after a tick wrapped the pointer
//   busy        high during every clear sweep cycle
module looper_engine #(
    parameter int TRACKS = 8,
    parameter int NOTE_W = 8,
    parameter int ADDR_W = 7
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       run,
    input  logic                       step_tick,
    input  logic                       rewind,
    input  logic [TRACKS-1:0]          rec_en,
    input  logic                       overdub,
    input  logic [NOTE_W-1:0]          data_in,
    input  logic [ADDR_W-1:0]          loop_len,
    input  logic [TRACKS-1:0]          mute,
    input  logic                       clear_req,
    input  logic [TRACKS-1:0]          clear_mask,
    output logic [TRACKS*NOTE_W-1:0]   notes_out,
    output logic [ADDR_W-1:0]          step_pos,
    output logic                       loop_wrap,
    output logic                       busy
);

    localparam int STEPS = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    state_t                      state_q, state_d;
    logic [ADDR_W-1:0]           step_pos_q, step_pos_d;
    logic                        wrap_q, wrap_d;
    logic [TRACKS*NOTE_W-1:0]    notes_q, notes_d;
    logic [ADDR_W-1:0]           clr_addr_q;
    logic [TRACKS-1:0]           mask_q;

    // Note storage is deliberately outside the reset domain: contents
    // survive reset and are only erased by a clear sweep.
    logic [NOTE_W-1:0]           mem_q [TRACKS][STEPS];

    logic                        clear_go;
    logic                        tick_go;
    logic                        rewind_go;
    logic                        sweeping;
    logic                        at_end;
    logic [ADDR_W:0]             len_full;
    logic [NOTE_W-1:0]           rd_word [TRACKS];
    logic [TRACKS-1:0]           wr_en;
    logic [NOTE_W-1:0]           wr_data [TRACKS];
    logic [ADDR_W-1:0]           wr_addr;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (clear_req)  state_d = ST_CLEAR;
                else if (run)   state_d = ST_PLAY;
            end
            ST_PLAY: begin
                if (clear_req)  state_d = ST_CLEAR;
                else if (!run)  state_d = ST_IDLE;
            end
            ST_CLEAR: begin
                if (clr_addr_q == ADDR_W'(STEPS - 1)) begin
                    state_d = run ? ST_PLAY : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs / action strobes ----------------
    // A clear request pre-empts tick and rewind in the same cycle.
    // Strobes are gated by reset so nothing is written while it is held.
    always_comb begin
        clear_go  = 1'b0;
        tick_go   = 1'b0;
        rewind_go = 1'b0;
        sweeping  = 1'b0;
        busy      = (state_q == ST_CLEAR);
        if (reset) begin
            case (state_q)
                ST_IDLE: begin
                    clear_go  = clear_req;
                    rewind_go = rewind && !clear_req;
                end
                ST_PLAY: begin
                    clear_go  = clear_req;
                    tick_go   = step_tick && !clear_req;
                    rewind_go = rewind && !clear_req;
                end
                ST_CLEAR: sweeping = 1'b1;
                default: ;
            endcase
        end
    end

    // ---------------- step pointer ----------------
    // Compare in ADDR_W+1 bits so a loop of full STEPS length is representable.
    always_comb begin
        len_full   = (loop_len == '0) ? (ADDR_W+1)'(STEPS) : {1'b0, loop_len};
        at_end     = ({1'b0, step_pos_q} >= (len_full - 1'b1));
        step_pos_d = step_pos_q;
        wrap_d     = 1'b0;
        if (rewind_go) begin
            step_pos_d = '0;
        end else if (tick_go) begin
            step_pos_d = at_end ? '0 : step_pos_q + 1'b1;
            wrap_d     = at_end;
        end
    end

    // ---------------- memory write port per track ----------------
    always_comb begin
        wr_addr = sweeping ? clr_addr_q : step_pos_q;
        for (int i = 0; i < TRACKS; i++) begin
            rd_word[i] = mem_q[i][step_pos_q];
            if (sweeping) begin
                wr_en[i]   = mask_q[i];
                wr_data[i] = '0;
            end else begin
                wr_en[i]   = tick_go && rec_en[i];
                wr_data[i] = overdub ? (rd_word[i] | data_in) : data_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < TRACKS; i++) begin
            if (wr_en[i]) begin
                mem_q[i][wr_addr] <= wr_data[i];
            end
        end
    end

    // ---------------- output word ----------------
    // Gating on the next state makes notes_out read zero for every CLEAR cycle.
    always_comb begin
        for (int i = 0; i < TRACKS; i++) begin
            notes_d[i*NOTE_W +: NOTE_W] =
                ((state_d == ST_CLEAR) || mute[i]) ? '0 : rd_word[i];
        end
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            step_pos_q <= '0;
            wrap_q     <= 1'b0;
            notes_q    <= '0;
            clr_addr_q <= '0;
            mask_q     <= '0;
        end else begin
            step_pos_q <= step_pos_d;
            wrap_q     <= wrap_d;
            notes_q    <= notes_d;
            if (clear_go) begin
                clr_addr_q <= '0;
                mask_q     <= clear_mask;
            end else if (sweeping) begin
                clr_addr_q <= clr_addr_q + 1'b1;
            end
        end
    end

    assign notes_out = notes_q;
    assign step_pos  = step_pos_q;
    assign loop_wrap = wrap_q;

endmodule

// File: tb/tb_looper_engine.sv
// tb/tb_looper_engine.sv - scoreboard bench for looper_engine
module tb_looper_engine;

    localparam int TRACKS = 8;
    localparam int NOTE_W = 8;
    localparam int ADDR_W = 7;
    localparam int STEPS  = 128;

    logic                      clk = 1'b0;
    logic                      reset;
    logic                      run;
    logic                      step_tick;
    logic                      rewind;
    logic [TRACKS-1:0]         rec_en;
    logic                      overdub;
    logic [NOTE_W-1:0]         data_in;
    logic [ADDR_W-1:0]         loop_len;
    logic [TRACKS-1:0]         mute;
    logic                      clear_req;
    logic [TRACKS-1:0]         clear_mask;
    logic [TRACKS*NOTE_W-1:0]  notes_out;
    logic [ADDR_W-1:0]         step_pos;
    logic                      loop_wrap;
    logic                      busy;

    looper_engine #(.TRACKS(TRACKS), .NOTE_W(NOTE_W), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .step_tick  (step_tick),
        .rewind     (rewind),
        .rec_en     (rec_en),
        .overdub    (overdub),
        .data_in    (data_in),
        .loop_len   (loop_len),
        .mute       (mute),
        .clear_req  (clear_req),
        .clear_mask (clear_mask),
        .notes_out  (notes_out),
        .step_pos   (step_pos),
        .loop_wrap  (loop_wrap),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [63:0] exp_q [$];
    string       tag_q [$];
    logic [7:0]  m_mem [TRACKS][STEPS];
    int          m_pos = 0;
    int          nbusy;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic [63:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic pop_chk(input logic [63:0] obs);
        if (exp_q.size() == 0) chk("sb_underflow", 64'(exp_q.size()), 64'd1);
        else chk(tag_q.pop_front(), obs, exp_q.pop_front());
    endtask

    function automatic logic [63:0] exp_notes(input int p);
        logic [63:0] r;
        for (int i = 0; i < TRACKS; i++) r[i*8 +: 8] = mute[i] ? 8'h00 : m_mem[i][p];
        return r;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_tick(input logic [7:0] rec, input logic od, input logic [7:0] din, input logic rw);
        int  len;
        bit  w;
        len = (loop_len == 0) ? STEPS : int'(loop_len);
        step_tick = 1'b1; rec_en = rec; overdub = od; data_in = din; rewind = rw;
        for (int i = 0; i < TRACKS; i++)
            if (rec[i]) m_mem[i][m_pos] = od ? (m_mem[i][m_pos] | din) : din;
        w = !rw && (m_pos >= len - 1);
        m_pos = (rw || (m_pos >= len - 1)) ? 0 : m_pos + 1;
        push("tick_pos", 64'(m_pos));
        push("tick_wrap", 64'(w));
        cyc();
        step_tick = 1'b0; rewind = 1'b0; rec_en = '0;
        pop_chk(64'(step_pos));
        pop_chk(64'(loop_wrap));
        push("tick_notes", exp_notes(m_pos));
        cyc();
        pop_chk(notes_out);
        if (w) begin
            push("wrap_pulse", 64'd0);
            pop_chk(64'(loop_wrap));
        end
    endtask

    task automatic rewind_only();
        rewind = 1'b1;
        m_pos = 0;
        push("rw_pos", 64'd0);
        push("rw_wrap", 64'd0);
        cyc();
        rewind = 1'b0;
        pop_chk(64'(step_pos));
        pop_chk(64'(loop_wrap));
    endtask

    task automatic clear_sweep(input logic [7:0] mask, input logic with_tick, output int n);
        clear_req = 1'b1; clear_mask = mask;
        step_tick = with_tick; rec_en = with_tick ? 8'h01 : 8'h00; data_in = 8'hFF; overdub = 1'b0;
        push("clr_pos", 64'(m_pos));
        cyc();
        clear_req = 1'b0; step_tick = 1'b0; rec_en = '0;
        pop_chk(64'(step_pos));
        for (int i = 0; i < TRACKS; i++)
            if (mask[i]) for (int a = 0; a < STEPS; a++) m_mem[i][a] = 8'h00;
        n = 0;
        while (busy === 1'b1 && n < 400) begin
            n++;
            if (n == 1 || n == 64) begin
                push("clr_notes", 64'd0);
                pop_chk(notes_out);
            end
            cyc();
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < TRACKS; i++) for (int a = 0; a < STEPS; a++) m_mem[i][a] = 8'h00;
        reset = 1'b0; run = 1'b0; step_tick = 1'b0; rewind = 1'b0; rec_en = '0;
        overdub = 1'b0; data_in = '0; loop_len = '0; mute = '0; clear_req = 1'b0; clear_mask = '0;
        repeat (2) cyc();
        chk("rst_pos", 64'(step_pos), 64'd0);
        chk("rst_notes", notes_out, 64'd0);
        chk("rst_wrap", 64'(loop_wrap), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        reset = 1'b1;
        cyc();

        // full erase then a 4-step loop
        run = 1'b1;
        clear_sweep(8'hFF, 1'b0, nbusy);
        chk("busy_cycles_full", 64'(nbusy), 64'd128);
        chk("post_clr_pos", 64'(step_pos), 64'd0);
        loop_len = 7'd4;
        for (int k = 0; k < 6; k++) do_tick(8'h00, 1'b0, 8'h00, 1'b0);
        rewind_only();

        // record track 0, then play back
        do_tick(8'h01, 1'b0, 8'h11, 1'b0);
        do_tick(8'h01, 1'b0, 8'h22, 1'b0);
        do_tick(8'h01, 1'b0, 8'h33, 1'b0);
        do_tick(8'h01, 1'b0, 8'h44, 1'b0);
        for (int k = 0; k < 4; k++) do_tick(8'h00, 1'b0, 8'h00, 1'b0);

        // overdub 0x80 over the loop, then play back
        for (int k = 0; k < 4; k++) do_tick(8'h01, 1'b1, 8'h80, 1'b0);
        for (int k = 0; k < 4; k++) do_tick(8'h00, 1'b0, 8'h00, 1'b0);
        chk("overdub_step0", notes_out, 64'h91);

        // mute / unmute track 0
        mute = 8'h01;
        cyc();
        chk("mute_on", notes_out, exp_notes(m_pos));
        mute = 8'h00;
        cyc();
        chk("mute_off", notes_out, exp_notes(m_pos));

        // loop_len shrunk under the pointer; rewind together with tick
        loop_len = 7'd8;
        for (int k = 0; k < 3; k++) do_tick(8'h00, 1'b0, 8'h00, 1'b0);
        chk("pos_before_shrink", 64'(step_pos), 64'd3);
        loop_len = 7'd2;
        do_tick(8'h00, 1'b0, 8'h00, 1'b0);
        do_tick(8'h00, 1'b0, 8'h00, 1'b0);
        do_tick(8'h01, 1'b0, 8'h5A, 1'b1);
        do_tick(8'h00, 1'b0, 8'h00, 1'b0);

        // fill track 1, then clear it with a simultaneous tick
        loop_len = 7'd4;
        for (int k = 0; k < 4; k++) do_tick(8'h02, 1'b0, 8'h77, 1'b0);
        clear_sweep(8'h02, 1'b1, nbusy);
        chk("busy_cycles_mask", 64'(nbusy), 64'd128);
        for (int k = 0; k < 4; k++) do_tick(8'h00, 1'b0, 8'h00, 1'b0);

        // fill track 2 at every address, then reset mid-clear
        loop_len = 7'd0;
        rewind_only();
        for (int k = 0; k < STEPS; k++) do_tick(8'h04, 1'b0, {m_pos[6:0], 1'b1}, 1'b0);
        clear_req = 1'b1; clear_mask = 8'h04;
        cyc();
        clear_req = 1'b0;
        chk("mid_busy_first", 64'(busy), 64'd1);
        repeat (50) cyc();
        chk("mid_busy_51", 64'(busy), 64'd1);
        reset = 1'b0;
        cyc();
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_pos", 64'(step_pos), 64'd0);
        chk("abort_notes", notes_out, 64'd0);
        chk("abort_wrap", 64'(loop_wrap), 64'd0);
        for (int a = 0; a < 50; a++) m_mem[2][a] = 8'h00;
        m_pos = 0;
        run = 1'b0;
        reset = 1'b1;
        cyc();

        // IDLE: tick ignored, no write, notes still follow memory
        step_tick = 1'b1; rec_en = 8'hFF; data_in = 8'hFF;
        cyc();
        step_tick = 1'b0; rec_en = '0;
        chk("idle_pos", 64'(step_pos), 64'd0);
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_notes", notes_out, exp_notes(0));
        run = 1'b1;
        cyc();
        for (int k = 0; k < STEPS; k++) do_tick(8'h00, 1'b0, 8'h00, 1'b0);

        chk("sb_drain", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
